// File: rtl/rpn_pkg.sv
// Shared opcode/state definitions and size defaults for the RPN stack controller.
package rpn_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_DUP  = 3'd6,
    OP_DROP = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP_B  = 2'd1,
    POP_A  = 2'd2,
    PUSH_R = 2'd3
  } state_e;

  // Two-operand opcodes consume two entries and push one result.
  function automatic logic is_binop(input opcode_e op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU; all arithmetic wraps modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  opcode_e          i_op,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_res
);

  // Result select; opa is second-from-top, opb is the former top.
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = i_opa + i_opb;
      OP_SUB:  o_res = i_opa - i_opb;
      OP_AND:  o_res = i_opa & i_opb;
      OP_OR:   o_res = i_opa | i_opb;
      OP_XOR:  o_res = i_opa ^ i_opb;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer driving an external push/pop stack; tracks depth locally.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_imm,
  output logic                     cmd_ready,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [WIDTH-1:0]         stk_wdata,
  input  logic [WIDTH-1:0]         stk_rdata,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     err_underflow,
  output logic                     err_overflow
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e           r_state;
  state_e           w_next;
  opcode_e          r_op;
  opcode_e          w_op;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] w_alu_res;
  logic [DW-1:0]    r_depth;
  logic             r_err_uf;
  logic             r_err_of;
  logic             w_accept;
  logic             w_uf;
  logic             w_of;
  logic             w_start;
  logic             w_push;
  logic             w_pop;
  logic             w_ready;

  assign w_op     = opcode_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_uf     = (is_binop(w_op) && (r_depth < DW'(2))) ||
                    (((w_op == OP_DUP) || (w_op == OP_DROP)) && (r_depth == '0));
  assign w_of     = ((w_op == OP_PUSH) || (w_op == OP_DUP)) && (r_depth == FULL);
  // A rejected command is still consumed: it only raises its error pulse.
  assign w_start  = w_accept && !w_uf && !w_of;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op  (r_op),
    .i_opa (r_opa),
    .i_opb (r_opb),
    .o_res (w_alu_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and Moore strobes.
  always_comb begin
    w_next  = r_state;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_start) begin
          case (w_op)
            OP_PUSH, OP_DUP: w_next = PUSH_R;
            OP_DROP:         w_next = POP_A;
            default:         w_next = POP_B;
          endcase
        end
      end
      POP_B: begin
        w_pop  = 1'b1;
        w_next = POP_A;
      end
      POP_A: begin
        w_pop  = 1'b1;
        w_next = is_binop(r_op) ? PUSH_R : IDLE;
      end
      PUSH_R: begin
        w_push = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command capture, operand latches and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op     <= OP_PUSH;
      r_opa    <= '0;
      r_opb    <= '0;
      r_wdata  <= '0;
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
    end else begin
      r_err_uf <= w_accept && w_uf;
      r_err_of <= w_accept && w_of;
      if (w_start) begin
        r_op <= w_op;
        if (w_op == OP_PUSH)     r_wdata <= cmd_imm;
        else if (w_op == OP_DUP) r_wdata <= stk_rdata;
      end
      if (r_state == POP_B)                     r_opb <= stk_rdata;
      if ((r_state == POP_A) && is_binop(r_op)) r_opa <= stk_rdata;
    end
  end

  // Entry counter mirroring the stack, saturating at both ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (w_push && (r_depth != FULL)) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_pop && (r_depth != '0)) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign cmd_ready     = w_ready;
  assign stk_push      = w_push;
  assign stk_pop       = w_pop;
  assign stk_wdata     = ((r_state == PUSH_R) && is_binop(r_op)) ? w_alu_res : r_wdata;
  assign depth         = r_depth;
  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl paired with an 8x8 push/pop stack model.
module tb_rpn_stack_ctrl;

  localparam logic [2:0] C_PUSH = 3'd0, C_ADD = 3'd1, C_SUB = 3'd2, C_AND = 3'd3,
                         C_OR = 3'd4, C_XOR = 3'd5, C_DUP = 3'd6, C_DROP = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic       cmd_ready, stk_push, stk_pop, err_underflow, err_overflow;
  logic [7:0] stk_wdata, stk_rdata;
  logic [3:0] depth;

  always #5 clk = ~clk;

  rpn_stack_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_imm       (cmd_imm),
    .cmd_ready     (cmd_ready),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_wdata     (stk_wdata),
    .stk_rdata     (stk_rdata),
    .depth         (depth),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  // 8x8 stack model sharing the controller's reset
  logic [7:0] mem [8];
  logic [3:0] sp;
  always @(posedge clk) begin
    if (!reset) sp <= 4'd0;
    else if (stk_push && (sp < 4'd8)) begin
      mem[sp[2:0]] <= stk_wdata;
      sp <= sp + 4'd1;
    end else if (stk_pop && (sp > 4'd0)) sp <= sp - 4'd1;
  end
  assign stk_rdata = (sp == 4'd0) ? 8'h00 : mem[3'(sp - 4'd1)];

  int push_cnt = 0, pop_cnt = 0, uf_cnt = 0, of_cnt = 0, ovl_cnt = 0;
  always @(negedge clk) begin
    if (stk_push) push_cnt++;
    if (stk_pop) pop_cnt++;
    if (err_underflow) uf_cnt++;
    if (err_overflow) of_cnt++;
    if (stk_push && stk_pop) ovl_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Offer one command in IDLE, then wait for ready; report busy cycles, error pulses, strobes.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm,
                        output int busy, output int duf, output int dof, output int dstb);
    int uf0, of0, p0, q0, n;
    uf0 = uf_cnt; of0 = of_cnt; p0 = push_cnt; q0 = pop_cnt;
    busy = 0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin busy++; @(negedge clk); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    duf = uf_cnt - uf0;
    dof = of_cnt - of0;
    dstb = (push_cnt - p0) + (pop_cnt - q0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    int top;   // -1: stack empty, top not checked
    int dep;
    int uf;
    int of;
    int busy;
    int stb;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int b, u, o, s, n, p0, q0;
    int q[$];

    tbl[0]  = '{C_PUSH, 8'h05, 'h05, 1, 0, 0, 1, 1};
    tbl[1]  = '{C_PUSH, 8'h03, 'h03, 2, 0, 0, 1, 1};
    tbl[2]  = '{C_SUB,  8'h00, 'h02, 1, 0, 0, 3, 3};
    tbl[3]  = '{C_DROP, 8'h00, -1,   0, 0, 0, 1, 1};
    tbl[4]  = '{C_PUSH, 8'h01, 'h01, 1, 0, 0, 1, 1};
    tbl[5]  = '{C_ADD,  8'h00, 'h01, 1, 1, 0, 0, 0};
    tbl[6]  = '{C_DROP, 8'h00, -1,   0, 0, 0, 1, 1};
    tbl[7]  = '{C_DROP, 8'h00, -1,   0, 1, 0, 0, 0};
    tbl[8]  = '{C_DUP,  8'h00, -1,   0, 1, 0, 0, 0};
    tbl[9]  = '{C_PUSH, 8'hF0, 'hF0, 1, 0, 0, 1, 1};
    tbl[10] = '{C_DUP,  8'h00, 'hF0, 2, 0, 0, 1, 1};
    tbl[11] = '{C_XOR,  8'h00, 'h00, 1, 0, 0, 3, 3};
    tbl[12] = '{C_PUSH, 8'h0F, 'h0F, 2, 0, 0, 1, 1};
    tbl[13] = '{C_OR,   8'h00, 'h0F, 1, 0, 0, 3, 3};
    tbl[14] = '{C_PUSH, 8'h3C, 'h3C, 2, 0, 0, 1, 1};
    tbl[15] = '{C_AND,  8'h00, 'h0C, 1, 0, 0, 3, 3};
    tbl[16] = '{C_PUSH, 8'h10, 'h10, 2, 0, 0, 1, 1};
    tbl[17] = '{C_SUB,  8'h00, 'hFC, 1, 0, 0, 3, 3};
    tbl[18] = '{C_DROP, 8'h00, -1,   0, 0, 0, 1, 1};

    // reset state
    do_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_wdata", stk_wdata, 0);
    chk("rst_uf", err_underflow, 0);
    chk("rst_of", err_overflow, 0);

    // table-driven sequence
    for (int i = 0; i < 19; i++) begin
      do_cmd(tbl[i].op, tbl[i].imm, b, u, o, s);
      chk($sformatf("vec%0d_depth", i), depth, tbl[i].dep);
      if (tbl[i].top >= 0) chk($sformatf("vec%0d_top", i), stk_rdata, tbl[i].top);
      chk($sformatf("vec%0d_uf", i), u, tbl[i].uf);
      chk($sformatf("vec%0d_of", i), o, tbl[i].of);
      chk($sformatf("vec%0d_busy", i), b, tbl[i].busy);
      chk($sformatf("vec%0d_strobes", i), s, tbl[i].stb);
    end

    // fill to capacity, overflow, then a binary op on a full stack
    for (int i = 0; i < 8; i++) do_cmd(C_PUSH, 8'hAA, b, u, o, s);
    chk("full_depth", depth, 8);
    do_cmd(C_PUSH, 8'h55, b, u, o, s);
    chk("ovf_pulse", o, 1);
    chk("ovf_strobes", s, 0);
    chk("ovf_depth", depth, 8);
    chk("ovf_top", stk_rdata, 'hAA);
    do_cmd(C_ADD, 8'h00, b, u, o, s);
    chk("full_add_top", stk_rdata, 'h54);
    chk("full_add_depth", depth, 7);
    chk("full_add_busy", b, 3);
    chk("full_add_uf", u, 0);

    // cmd_valid held high across two ADDs: one accept per IDLE cycle
    do_reset();
    for (int i = 1; i <= 4; i++) do_cmd(C_PUSH, 8'(i), b, u, o, s);
    p0 = push_cnt; q0 = pop_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_ADD; cmd_imm = 8'h00;
    repeat (8) @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("hold_ready_timeout", 0, 1);
    chk("hold_depth", depth, 2);
    chk("hold_top", stk_rdata, 9);
    chk("hold_pushes", push_cnt - p0, 2);
    chk("hold_pops", pop_cnt - q0, 4);

    // reset asserted while an ADD is in POP_A
    do_reset();
    do_cmd(C_PUSH, 8'h11, b, u, o, s);
    do_cmd(C_PUSH, 8'h22, b, u, o, s);
    p0 = push_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = C_ADD;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_in_popa", stk_pop, 1);
    @(posedge clk);
    #1;
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_depth", depth, 0);
    chk("midrst_push", stk_push, 0);
    chk("midrst_pop", stk_pop, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_push", push_cnt - p0, 0);
    chk("midrst_depth_after", depth, 0);

    // randomized commands against a queue-based reference
    do_reset();
    q.delete();
    for (int i = 0; i < 300; i++) begin
      int r, sz, va, vb, res, eb;
      logic [2:0] op;
      logic [7:0] imm;
      bit bin, euf, eof;
      r = $urandom_range(0, 11);
      op = (r < 5) ? C_PUSH : 3'(r - 4);
      imm = 8'($urandom);
      sz = q.size();
      bin = (op >= C_ADD) && (op <= C_XOR);
      euf = (bin && sz < 2) || ((op == C_DUP || op == C_DROP) && sz == 0);
      eof = !euf && (op == C_PUSH || op == C_DUP) && sz == 8;
      eb = 0;
      if (!euf && !eof) begin
        if (op == C_PUSH) begin q.push_back(int'(imm)); eb = 1; end
        else if (op == C_DUP) begin q.push_back(q[$]); eb = 1; end
        else if (op == C_DROP) begin void'(q.pop_back()); eb = 1; end
        else begin
          vb = q.pop_back();
          va = q.pop_back();
          case (op)
            C_ADD:   res = (va + vb) & 'hFF;
            C_SUB:   res = (va - vb + 256) & 'hFF;
            C_AND:   res = va & vb;
            C_OR:    res = va | vb;
            default: res = va ^ vb;
          endcase
          q.push_back(res);
          eb = 3;
        end
      end
      do_cmd(op, imm, b, u, o, s);
      chk($sformatf("rnd%0d_depth", i), depth, q.size());
      if (q.size() > 0) chk($sformatf("rnd%0d_top", i), stk_rdata, q[$]);
      chk($sformatf("rnd%0d_uf", i), u, int'(euf));
      chk($sformatf("rnd%0d_of", i), o, int'(eof));
      chk($sformatf("rnd%0d_busy", i), b, eb);
      chk($sformatf("rnd%0d_strobes", i), s, eb);
    end
    for (int k = 0; k < q.size(); k++) chk($sformatf("rnd_final_entry%0d", k), mem[k], q[k]);

    chk("strobe_overlap", ovl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
